// File: rtl/glbl_cfg_bank.sv
// glbl_cfg_bank: a bank of NUM_REGS 32-bit configuration/status registers on
// the reg-bus. Each register can be read/write, read-only (live hw_status),
// or write-1-to-clear interrupt status. A key register at index NUM_REGS
// opens a timed write window for LOCK_MASK registers.
//
// Ports:
//   mclk       in   clock
//   reset      in   asynchronous active-high reset
//   reg_cs     in   access request, held until reg_ack
//   reg_wr     in   1 = write, 0 = read
//   reg_addr   in   byte address, index = reg_addr[AW-1:2]
//   reg_wdata  in   write data
//   reg_be     in   byte enables
//   reg_rdata  out  read data, valid with reg_ack (holds between reads)
//   reg_ack    out  one-cycle completion pulse
//   reg_err    out  error flag, valid with reg_ack
//   hw_status  in   live values for read-only registers
//   hw_set     in   per-bit set pulses for W1C registers
//   cfg_out    out  current register contents
//   irq        out  registered OR of all W1C bits
//   lock_sts   out  1 = locked
module glbl_cfg_bank #(
  parameter int                     NUM_REGS   = 16,
  parameter int                     AW         = 8,
  parameter logic [32*NUM_REGS-1:0] RST_VAL    = '0,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]    W1C_MASK   = '0,
  parameter logic [NUM_REGS-1:0]    LOCK_MASK  = '0,
  parameter logic [31:0]            UNLOCK_KEY = 32'hA5C3_0F96,
  parameter int                     UNLOCK_WIN = 64
) (
  input  logic                     mclk,
  input  logic                     reset,
  input  logic                     reg_cs,
  input  logic                     reg_wr,
  input  logic [AW-1:0]            reg_addr,
  input  logic [31:0]              reg_wdata,
  input  logic [3:0]               reg_be,
  output logic [31:0]              reg_rdata,
  output logic                     reg_ack,
  output logic                     reg_err,
  input  logic [32*NUM_REGS-1:0]   hw_status,
  input  logic [32*NUM_REGS-1:0]   hw_set,
  output logic [32*NUM_REGS-1:0]   cfg_out,
  output logic                     irq,
  output logic                     lock_sts
);

  localparam int IW = AW - 2;
  // W1C registers are never lockable.
  localparam logic [NUM_REGS-1:0] EFF_LOCK = LOCK_MASK & ~W1C_MASK;

  typedef enum logic {ST_LOCKED, ST_UNLOCKED} lock_state_t;

  lock_state_t r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_rdata;
  logic        r_ack;
  logic        r_err;
  logic        r_irq;

  logic [IW-1:0]                w_idx;
  logic                         w_cap;
  logic                         w_wr;
  logic [31:0]                  w_be_mask;
  logic                         w_key_hit;
  logic                         w_key_ok;
  logic                         w_unmapped;
  logic [NUM_REGS-1:0]          w_sel;
  logic [NUM_REGS-1:0]          w_we;
  logic                         w_ro_hit;
  logic                         w_lock_hit;
  logic                         w_err;
  logic                         w_wr_ok;
  logic [31:0]                  w_rd_val;
  logic [NUM_REGS-1:0][31:0]    w_cfg;
  logic [NUM_REGS-1:0][31:0]    w_w1c;
  logic                         w_unused_bits;

  assign w_idx      = reg_addr[AW-1:2];
  // A new access is only taken while ack is low, so ack is always a pulse.
  assign w_cap      = reg_cs & ~r_ack;
  assign w_wr       = w_cap & reg_wr;
  assign w_be_mask  = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
  assign w_key_hit  = (w_idx == IW'(NUM_REGS));
  assign w_unmapped = (w_idx > IW'(NUM_REGS));
  assign w_key_ok   = (reg_wdata == UNLOCK_KEY) && (reg_be == 4'hF);
  assign w_ro_hit   = |(w_sel & RO_MASK);
  assign w_lock_hit = |(w_sel & EFF_LOCK);

  assign w_err = w_unmapped |
                 (reg_wr & (w_ro_hit | (w_lock_hit & lock_sts) | (w_key_hit & ~w_key_ok)));
  assign w_wr_ok = w_wr & ~w_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign w_sel[gi] = (w_idx == IW'(gi));
      assign w_we[gi]  = w_wr_ok & w_sel[gi];

      if (RO_MASK[gi]) begin : g_ro
        assign w_cfg[gi] = hw_status[32*gi +: 32];
        assign w_w1c[gi] = '0;
      end else if (W1C_MASK[gi]) begin : g_w1c
        logic [31:0] r_val;
        logic [31:0] w_clr;
        assign w_clr = w_we[gi] ? (reg_wdata & w_be_mask) : 32'h0;
        // Set is OR-ed in after the clear so a same-cycle set wins.
        always_ff @(posedge mclk or posedge reset) begin
          if (reset) r_val <= RST_VAL[32*gi +: 32];
          else       r_val <= (r_val & ~w_clr) | hw_set[32*gi +: 32];
        end
        assign w_cfg[gi] = r_val;
        assign w_w1c[gi] = r_val;
      end else begin : g_rw
        logic [31:0] r_val;
        always_ff @(posedge mclk or posedge reset) begin
          if (reset)          r_val <= RST_VAL[32*gi +: 32];
          else if (w_we[gi])  r_val <= (r_val & ~w_be_mask) | (reg_wdata & w_be_mask);
        end
        assign w_cfg[gi] = r_val;
        assign w_w1c[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    w_rd_val = 32'h0;
    if (w_key_hit) w_rd_val = {31'b0, lock_sts};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_sel[i]) w_rd_val = w_cfg[i];
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_LOCKED;
      r_cnt   <= 8'd0;
      r_rdata <= 32'h0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_ack <= w_cap;
      r_err <= w_cap & w_err;
      if (w_cap && !reg_wr) r_rdata <= w_rd_val;
      r_irq <= |w_w1c;

      case (r_state)
        ST_LOCKED: begin
          if (w_wr && w_key_hit && w_key_ok) begin
            r_state <= ST_UNLOCKED;
            r_cnt   <= 8'(UNLOCK_WIN);
          end
        end
        ST_UNLOCKED: begin
          if (w_wr && w_key_hit) begin
            // Correct key reloads the window, wrong key slams it shut.
            if (w_key_ok) begin
              r_cnt <= 8'(UNLOCK_WIN);
            end else begin
              r_state <= ST_LOCKED;
              r_cnt   <= 8'd0;
            end
          end else if (w_wr_ok && w_lock_hit) begin
            // Single-shot: one protected write per unlock.
            r_state <= ST_LOCKED;
            r_cnt   <= 8'd0;
          end else if (r_cnt <= 8'd1) begin
            r_state <= ST_LOCKED;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_LOCKED;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign w_unused_bits = ^{hw_status, hw_set, reg_addr[1:0], w_we};

  assign reg_rdata = r_rdata;
  assign reg_ack   = r_ack;
  assign reg_err   = r_err;
  assign irq       = r_irq;
  assign lock_sts  = (r_state == ST_LOCKED);
  assign cfg_out   = w_cfg;

endmodule

// File: doc/glbl_cfg_bank.md
Name: glbl_cfg_bank

Overview:
- Parametrised successor to the global config block: a bank of NUM_REGS 32-bit registers on the same reg-bus (cs/wr/addr/wdata/be, registered ack).
- Each register is typed per-index as read/write, read-only (hardware status), or write-1-to-clear interrupt status.
- Adds a key-unlocked write-protect window, error response, and an aggregated interrupt.
- Sits at the top of the user area beside the MAC/clock controllers and replaces the fixed 12-register decode.

Parameters:
- NUM_REGS, 16, number of mapped registers; 1..63. Index NUM_REGS is the key register.
- AW, 8, reg_addr width; requires NUM_REGS+1 <= 2^(AW-2).
- RST_VAL, {NUM_REGS{32'h0}}, packed reset values, register i at [32i+31:32i].
- RO_MASK, 'h0, bit i=1: register i is read-only and reads hw_status[i].
- W1C_MASK, 'h0, bit i=1: register i is W1C status. Must not overlap RO_MASK.
- LOCK_MASK, 'h0, bit i=1: register i is writable only while unlocked.
- UNLOCK_KEY, 32'hA5C3_0F96, key value that opens the lock.
- UNLOCK_WIN, 64, unlock window length in mclk cycles; 1..255.

Ports:
- mclk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- reg_cs  in  1  access request; held until reg_ack
- reg_wr  in  1  1=write, 0=read
- reg_addr  in  AW  byte address; index = reg_addr[AW-1:2]
- reg_wdata  in  32  write data
- reg_be  in  4  byte enables
- reg_rdata  out  32  read data, valid with reg_ack
- reg_ack  out  1  one-cycle access completion
- reg_err  out  1  error flag, valid with reg_ack
- hw_status  in  32*NUM_REGS  live values for RO registers
- hw_set  in  32*NUM_REGS  per-bit set pulses for W1C registers
- cfg_out  out  32*NUM_REGS  current register contents
- irq  out  1  registered OR of all W1C bits
- lock_sts  out  1  1=locked

Behaviour:
- Reset values: reg_rdata=0, reg_ack=0, reg_err=0, irq=0, lock_sts=1, unlock counter=0, RW/W1C registers=RST_VAL. RO registers hold no state.
- Handshake:
  - When reg_cs=1 and reg_ack=0, the access is captured on the mclk edge. reg_ack, reg_rdata and reg_err update on that edge, so latency is 1 cycle.
  - The cycle after reg_ack is forced low (ack is a pulse). A reg_cs held high therefore gets one ack every 2 cycles.
  - reg_rdata holds its value between accesses.
- Reads:
  - RW/W1C registers return stored contents.
  - RO registers return hw_status[i] sampled in the capture cycle.
  - The key register returns {31'b0, lock_sts}.
  - An index > NUM_REGS returns 0 with reg_err=1.
- Writes to RW registers update only the bytes enabled by reg_be. reg_be=0 is a legal no-op that still acks.
- W1C registers:
  - Each bit is set by hw_set (1-cycle pulse, any cycle).
  - Each bit is cleared by writing 1 on an enabled byte.
  - If set and clear hit the same bit in the same cycle, set wins.
  - W1C registers are never lockable; LOCK_MASK bits overlapping W1C_MASK are ignored.
- Errors (reg_err=1, ack still given, no state change):
  - unmapped index;
  - write to an RO register;
  - write to a LOCK_MASK register while lock_sts=1;
  - key write with the wrong value or with reg_be != 4'hF.
- Lock state machine (LOCKED, UNLOCKED):
  - LOCKED -> UNLOCKED: write UNLOCK_KEY with reg_be=4'hF to the key index. Counter loads UNLOCK_WIN; lock_sts falls on the ack edge.
  - UNLOCKED: counter decrements each cycle.
  - UNLOCKED -> LOCKED when the counter reaches 0, or after one successful write to any LOCK_MASK register (single-shot), or after a wrong key write. That write itself completes.
  - A correct key write while UNLOCKED reloads the counter.
- irq is registered: it follows W1C contents with 1 cycle of delay.
- Asserting reset mid-access drops reg_ack immediately and returns every register to its reset value. An access in flight is lost and the master must reissue it.

Test Plan:
- Reset, then read every index 0..NUM_REGS -> RST_VAL per index; key reads 32'h1; index NUM_REGS+1 -> rdata 0, reg_err=1; each ack exactly 1 cycle after reg_cs rises.
- Write 32'h1122_3344 to RW reg 2 with be=4'b0101 over RST_VAL 0 -> reads 32'h0022_0044; reg_cs held 6 cycles -> exactly 3 ack pulses.
- W1C reg 3: hw_set bit 5 pulses -> irq=1 next cycle. Write 32'h20 -> bit clears and irq falls. Repeat with hw_set and the clear in the same cycle -> bit stays 1.
- Locked reg 4 (LOCK_MASK): write 32'hFFFF_FFFF -> reg_err=1, value unchanged. Write the key, then reg 4 -> succeeds, lock_sts returns to 1 on that ack. A second write -> reg_err=1.
- UNLOCK_WIN=64: write the key, wait 64 cycles -> lock_sts=1 and a reg 4 write errors. A wrong key (32'h0) -> reg_err=1, lock_sts=1.
- Assert reset in the cycle reg_cs rises on a write to reg 2 -> no ack, reg 2 = RST_VAL, lock_sts=1.
